lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request, drives data memory, returns an extended result.
// Latency: aligned 2 cycles accept-to-resp, errors 1 cycle, split n+1; req_ready only in IDLE.
// Build option: MISALIGNED_SPLIT_EN turns misaligned H/W accesses into byte sequences instead of errors.
module lsu_ctrl #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_size,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
`ifdef MISALIGNED_SPLIT_EN
    localparam logic [1:0] S_SPLIT  = 2'd2;
`endif
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] buf_q, buf_d;
`ifdef MISALIGNED_SPLIT_EN
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] wdata_shift;
    logic        split_last;
`endif

    logic [2:0]  req_nbytes;
    logic        req_illegal, req_oor, req_misal, req_err;
    logic [32:0] req_end;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11)
                       || (req_we && req_funct3[2]);
    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign req_end   = {1'b0, req_addr} + {30'b0, req_nbytes};
    assign req_oor   = req_end > 33'(ADDR_LIMIT);
    assign req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                     || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef MISALIGNED_SPLIT_EN
    assign req_err   = req_illegal || req_oor;
    assign split_last = (funct3_q[1:0] == 2'b01) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
    assign wdata_shift = wdata_q >> {cnt_q, 3'b000};
`else
    assign req_err   = req_illegal || req_oor || req_misal;
`endif

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
`ifdef MISALIGNED_SPLIT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    buf_d = 32'b0;
`ifdef MISALIGNED_SPLIT_EN
                    cnt_d = 2'd0;
                    if (req_err)        state_d = S_RESP;
                    else if (req_misal) state_d = S_SPLIT;
                    else                state_d = S_ACCESS;
`else
                    state_d = req_err ? S_RESP : S_ACCESS;
`endif
                end
            end
            S_ACCESS: begin
                buf_d   = mem_rdata;
                state_d = S_RESP;
            end
`ifdef MISALIGNED_SPLIT_EN
            S_SPLIT: begin
                buf_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
                cnt_d = cnt_q + 2'd1;
                if (split_last) state_d = S_RESP;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            addr_q   <= 32'b0;
            wdata_q  <= 32'b0;
            buf_q    <= 32'b0;
`ifdef MISALIGNED_SPLIT_EN
            cnt_q    <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
`ifdef MISALIGNED_SPLIT_EN
            cnt_q   <= cnt_d;
`endif
            if (state_q == S_IDLE && req_valid) begin
                we_q     <= req_we;
                err_q    <= req_err;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'b0;
        mem_addr   = 32'b0;
        mem_wdata  = 32'b0;
        mem_size   = 3'b000;
        mem_wr_en  = 1'b0;
        mem_rd_en  = 1'b0;
        case (state_q)
            S_ACCESS: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_size  = {1'b0, funct3_q[1:0]};
                mem_wr_en = we_q;
                mem_rd_en = !we_q;
            end
`ifdef MISALIGNED_SPLIT_EN
            S_SPLIT: begin
                mem_addr  = addr_q + {30'b0, cnt_q};
                mem_wdata = {24'b0, wdata_shift[7:0]};
                mem_wr_en = we_q;
                mem_rd_en = !we_q;
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !we_q) begin
                    case (funct3_q)
                        3'b000:  resp_rdata = {{24{buf_q[7]}}, buf_q[7:0]};
                        3'b100:  resp_rdata = {24'b0, buf_q[7:0]};
                        3'b001:  resp_rdata = {{16{buf_q[15]}}, buf_q[15:0]};
                        3'b101:  resp_rdata = {16'b0, buf_q[15:0]};
                        default: resp_rdata = buf_q;
                    endcase
                end
            end
            default: ;
        endcase
        // Memory writes on the falling edge, so strobes must drop as soon as reset rises
        if (reset) begin
            mem_wr_en = 1'b0;
            mem_rd_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized bench for lsu_ctrl against a byte-array reference model; default ADDR_LIMIT 256.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;
    logic        mem_wr_en, mem_rd_en;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_LIMIT(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    logic [7:0] dmem    [0:255];
    logic [7:0] ref_mem [0:255];
    logic       loaded = 1'b0;

    always_comb begin
        mem_rdata = {dmem[mem_addr[7:0] + 8'd3], dmem[mem_addr[7:0] + 8'd2],
                     dmem[mem_addr[7:0] + 8'd1], dmem[mem_addr[7:0]]};
    end

    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 37 + 5);
            loaded <= 1'b1;
        end else if (mem_wr_en) begin
            dmem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_size != 3'b000) dmem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_size == 3'b010) begin
                dmem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                dmem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag, output logic [31:0] got);
        int nb, lat_exp, rd_exp, wr_exp, cycles, rd, wr, quiet, w;
        bit illegal, oor, mis, err, seen;
        logic [31:0] raw, exp_val;
        logic        got_err;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
        oor = (longint'(addr) + longint'(nb)) > 256;
        mis = (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0);
`ifdef MISALIGNED_SPLIT_EN
        err = illegal || oor;
`else
        err = illegal || oor || mis;
`endif
        lat_exp = err ? 1 : (mis ? nb + 1 : 2);
        rd_exp  = (err || we) ? 0 : (mis ? nb : 1);
        wr_exp  = (err || !we) ? 0 : (mis ? nb : 1);
        raw = 0;
        if (!err) for (int k = 0; k < nb; k++) raw = raw + (32'(ref_mem[(addr + k) & 255]) << (8 * k));
        exp_val = raw;
        if (f3 == 3'd0 && raw >= 128)   exp_val = raw - 256;
        if (f3 == 3'd1 && raw >= 32768) exp_val = raw - 65536;
        if (err || we) exp_val = 0;

        w = 0;
        while (!req_ready && w < 10) begin @(negedge clk); w++; end
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'(f3 + 3'd1);
        req_we = ~we;
        cycles = 0; rd = 0; wr = 0; quiet = 0; seen = 0; got = 32'hx; got_err = 1'bx;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            cycles++;
            if (mem_rd_en) rd++;
            if (mem_wr_en) wr++;
            if (resp_valid) begin
                seen = 1; got = resp_rdata; got_err = resp_err;
            end else if (resp_rdata != 0 || resp_err) quiet++;
            if (!mem_rd_en && !mem_wr_en && ((mem_addr | mem_wdata) != 0 || mem_size != 0)) quiet++;
        end
        chk({tag, ".lat"}, 32'(cycles), 32'(lat_exp));
        chk({tag, ".err"}, 32'(got_err), 32'(err));
        chk({tag, ".rdata"}, got, exp_val);
        chk({tag, ".rd_strobes"}, 32'(rd), 32'(rd_exp));
        chk({tag, ".wr_strobes"}, 32'(wr), 32'(wr_exp));
        chk({tag, ".quiet"}, 32'(quiet), 32'd0);
        if (!err && we) for (int k = 0; k < nb; k++) ref_mem[(addr + k) & 255] = 8'(wd >> (8 * k));
    endtask

    logic [2:0] f3_tab [0:12];
    logic [31:0] got, a;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst.ready", 32'(req_ready), 32'd1);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);

        do_req(1'b1, 3'd0, 32'h10, 32'h80, "sb_10", got);
        do_req(1'b0, 3'd0, 32'h10, 32'h0, "lb_10", got);
        chk("lb_10.const", got, 32'hFFFFFF80);
        do_req(1'b0, 3'd4, 32'h10, 32'h0, "lbu_10", got);
        chk("lbu_10.const", got, 32'h00000080);
        do_req(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, "sw_20", got);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, "lw_20", got);
        chk("lw_20.const", got, 32'hDEADBEEF);
        do_req(1'b0, 3'd1, 32'h22, 32'h0, "lh_22", got);
        chk("lh_22.const", got, 32'hFFFFDEAD);
        do_req(1'b0, 3'd5, 32'h22, 32'h0, "lhu_22", got);
        chk("lhu_22.const", got, 32'h0000DEAD);
        do_req(1'b1, 3'd2, 32'h21, 32'h11223344, "sw_21", got);
        do_req(1'b0, 3'd2, 32'h21, 32'h0, "lw_21", got);
`ifdef MISALIGNED_SPLIT_EN
        chk("lw_21.const", got, 32'h11223344);
`endif
        do_req(1'b0, 3'd3, 32'h40, 32'h0, "f3_011", got);
        do_req(1'b1, 3'd4, 32'h40, 32'h55, "sb_f3_100", got);
        do_req(1'b0, 3'd2, 32'hFD, 32'h0, "lw_fd", got);
        do_req(1'b0, 3'd0, 32'hFFFFFFFF, 32'h0, "lb_wrap", got);

        // Reset while the store to 0x30 is in its ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h30; req_wdata = 32'hA5A5A5A5;
        @(posedge clk);
        #1 req_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        chk("rst_acc.wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_acc.resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        begin
            int pulses = 0;
            repeat (4) begin @(negedge clk); if (resp_valid) pulses++; end
            chk("rst_acc.no_resp", 32'(pulses), 32'd0);
        end
        chk("rst_acc.ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, "lw_30_after_rst", got);

        for (int t = 0; t < 300; t++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 8)       a = 32'($urandom_range(0, 260));
            else if (r == 8) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            else             a = 32'h100 + 32'($urandom_range(0, 255));
            do_req(1'($urandom_range(0, 1)), f3_tab[$urandom_range(0, 12)], a, $urandom, "rand", got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
